multi_square: RTL
=================

MULTI_SQUARE -- requirements
Module: multi_square

Interface
REQ-001 Parameter FIELD_W, default 163: GF(2^163) element width; the reduction polynomial is x^163+x^7+x^6+x^3+1.
REQ-002 Parameter CNT_W, default 8: width of the squaring-count input.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request; sampled only in IDLE or DONE.
REQ-007 op_a  input  FIELD_W  operand; captured on an accepted start.
REQ-008 count  input  CNT_W  number of squarings k (0..255); captured on an accepted start.
REQ-009 busy  output  1  high while in RUN.
REQ-010 done  output  1  one-cycle pulse; result is valid in that cycle.
REQ-011 result  output  FIELD_W  value of op_a^(2^k); held from the done pulse until the next done.

Function
REQ-012 The block SHALL have three states:
- IDLE: waiting for start.
- RUN: squaring.
- DONE: one cycle, done=1.
REQ-013 IDLE or DONE with start=1: SHALL load acc<=op_a and rem<=count.
- If count==0, next state is DONE.
- Otherwise, next state is RUN.
REQ-014 IDLE or DONE with start=0: next state SHALL be IDLE.
REQ-015 In each RUN cycle the block SHALL update acc<=square(acc) and rem<=rem-1.
- When rem==1, next state is DONE.
REQ-016 On entry to DONE, result SHALL be loaded from acc.
REQ-017 Latency: start accepted in cycle 0 -> done in cycle k+1.
- k==0 -> done in cycle 1 with result==op_a.
REQ-018 start while busy=1 SHALL be ignored; no queuing.
REQ-019 start in the DONE cycle SHALL be accepted, giving back-to-back operation with no idle cycle.
REQ-020 op_a and count changes after capture SHALL NOT affect the operation in flight.
REQ-021 done SHALL never coincide with busy=1.

Reset
REQ-022 rst=1 SHALL force state=IDLE and acc=0, rem=0, result=0, busy=0, done=0 at the next clock edge.
REQ-023 rst during RUN SHALL abort the operation; no done pulse is issued for it.
REQ-024 rst=1 together with start=1: rst SHALL win.

Configuration
REQ-025 Macro MULTI_SQUARE_DOUBLE_EN defined:
- Two squarer instances are chained.
- Each RUN cycle applies two squarings (rem-=2) while rem>=2, and one squaring when rem==1.
- Latency is ceil(k/2)+1 cycles.
REQ-026 Macro MULTI_SQUARE_DOUBLE_EN undefined: a single squarer is used and latency follows REQ-017.
- Results SHALL be identical in both builds.

Structure
REQ-027 Shared package ecc_pkg SHALL hold FIELD_W, CNT_W and the state enumeration (IDLE, RUN, DONE).
REQ-028 The existing combinational squarer module square SHALL be instantiated as the sub-module:
- one instance by default;
- two chained instances under MULTI_SQUARE_DOUBLE_EN.
REQ-029 No other sub-modules; the FSM, counter and acc register SHALL be local.

Verification
REQ-030 op_a=1, k=5 -> result=1.
- done at cycle 6 (default build), cycle 4 (DOUBLE_EN).
REQ-031 op_a=bit162 only, k=1 -> result has bits {161,12,10,5,1} set, all other bits 0; done at cycle 2.
REQ-032 op_a=bit1 (x), k=7 -> result=bit128 only.
- Same op_a, k=163 -> result=bit1 (Frobenius identity); done at cycle 164 (default) or 83 (DOUBLE_EN).
REQ-033 k=0, op_a=0x5A5A...5 -> result=op_a, done at cycle 1, busy never asserted.
- Back-to-back start in the DONE cycle -> second op runs immediately with correct result.
REQ-034 rst asserted at cycle 3 of a k=10 run -> busy=0 next cycle, done never pulses.
- start pulses while busy are ignored; a subsequent op completes correctly.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared GF(2^163) field constants and the multi_square FSM state encoding.
package ecc_pkg;
  localparam int FIELD_W = 163;
  localparam int CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/square.sv
// Combinational GF(2^163) squarer, reduction polynomial x^163+x^7+x^6+x^3+1.
module square #(
  parameter int FIELD_W = 163
) (
  input  logic [FIELD_W-1:0] a,
  output logic [FIELD_W-1:0] y
);
  logic [2*FIELD_W-2:0] p;

  always_comb begin
    p = '0;
    // Squaring in characteristic 2 only spreads bit i to bit 2i.
    for (int i = 0; i < FIELD_W; i++) p[2*i] = a[i];
    // Fold from the top down so terms landing above FIELD_W-1 are folded again.
    for (int i = 2*FIELD_W-2; i >= FIELD_W; i--) begin
      if (p[i]) begin
        p[i-FIELD_W+7] = ~p[i-FIELD_W+7];
        p[i-FIELD_W+6] = ~p[i-FIELD_W+6];
        p[i-FIELD_W+3] = ~p[i-FIELD_W+3];
        p[i-FIELD_W]   = ~p[i-FIELD_W];
      end
    end
    y = p[FIELD_W-1:0];
  end
endmodule

// File: rtl/multi_square.sv
// Repeated GF(2^163) squaring: result = op_a^(2^count).
// Define MULTI_SQUARE_DOUBLE_EN to chain two squarers and halve the run length.
module multi_square #(
  parameter int FIELD_W = ecc_pkg::FIELD_W,
  parameter int CNT_W   = ecc_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [FIELD_W-1:0] op_a,
  input  logic [CNT_W-1:0]   count,
  output logic               busy,
  output logic               done,
  output logic [FIELD_W-1:0] result
);
  import ecc_pkg::*;

  state_t             state;
  logic [FIELD_W-1:0] acc;
  logic [CNT_W-1:0]   rem;
  logic [FIELD_W-1:0] sq1;

  square #(.FIELD_W(FIELD_W)) u_sq0 (.a(acc), .y(sq1));

`ifdef MULTI_SQUARE_DOUBLE_EN
  logic [FIELD_W-1:0] sq2;
  square #(.FIELD_W(FIELD_W)) u_sq1 (.a(sq1), .y(sq2));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      rem    <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            acc <= op_a;
            rem <= count;
            if (count == '0) begin
              state  <= DONE;
              result <= op_a;
              done   <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
`ifdef MULTI_SQUARE_DOUBLE_EN
          if (rem >= CNT_W'(2)) begin
            acc <= sq2;
            rem <= rem - CNT_W'(2);
            if (rem == CNT_W'(2)) begin
              state  <= DONE;
              result <= sq2;
              busy   <= 1'b0;
              done   <= 1'b1;
            end
          end else begin
            // Odd tail: one last single squaring.
            acc    <= sq1;
            rem    <= rem - CNT_W'(1);
            state  <= DONE;
            result <= sq1;
            busy   <= 1'b0;
            done   <= 1'b1;
          end
`else
          acc <= sq1;
          rem <= rem - CNT_W'(1);
          if (rem == CNT_W'(1)) begin
            state  <= DONE;
            result <= sq1;
            busy   <= 1'b0;
            done   <= 1'b1;
          end
`endif
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule
